// File: rtl/sap_1_controller_sequencer_pkg.sv
// Shared SAP-1 constants: opcode values, one-hot T-states and the decode-line bundle.
// The instruction register and control matrix import the same package.
package sap_1_controller_sequencer_pkg;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    typedef struct packed {
        logic lda;
        logic add;
        logic sub;
        logic out;
        logic hlt;
    } decode_t;

endpackage

// File: rtl/sap_1_controller_sequencer_opcode_decoder.sv
// Purely combinational opcode-to-decode-line mapping; unknown opcodes raise no line.
module sap_1_opcode_decoder
    import sap_1_controller_sequencer_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       lda,
    output logic       add,
    output logic       sub,
    output logic       out,
    output logic       hlt
);

    always_comb begin
        lda = 1'b0;
        add = 1'b0;
        sub = 1'b0;
        out = 1'b0;
        hlt = 1'b0;
        case (opcode)
            OPC_LDA: lda = 1'b1;
            OPC_ADD: add = 1'b1;
            OPC_SUB: sub = 1'b1;
            OPC_OUT: out = 1'b1;
            OPC_HLT: hlt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_1_controller_sequencer.sv
// SAP-1 controller-sequencer front end: T1..T6 ring counter, opcode latch,
// registered decode lines, HLT stop, free-run / single-step advance control.
module sap_1_controller_sequencer
    import sap_1_controller_sequencer_pkg::*;
#(
    parameter bit SHORT_CYCLE = 1'b0
) (
    input  logic       CLK,
    input  logic       CLRbar,
    input  logic [3:0] instr_opcode,
    input  logic       run_mode,
    input  logic       step,
    output logic [5:0] ring_counter,
    output logic       LDA,
    output logic       ADD,
    output logic       SUB,
    output logic       OUT,
    output logic       HLT,
    output logic       halted,
    output logic       instr_done
);

    t_state_e   ring_reg, ring_next;
    logic [3:0] opcode_reg, opcode_next;
    logic       step_prev_reg;
    logic       halted_reg, halted_next;
    logic       done_reg, done_next;
    decode_t    dec_reg, dec_next, dec_raw;
    logic       adv;
    logic       short_end;
    logic       dec_window;
    logic       dec_lda, dec_add, dec_sub, dec_out, dec_hlt;

    // Step is already debounced and CLK-synchronous, so a single-register edge detect suffices.
    assign adv       = !halted_reg && (run_mode || (step && !step_prev_reg));
    assign short_end = SHORT_CYCLE && (dec_reg.out || (dec_reg == '0));

    always_comb begin
        ring_next   = ring_reg;
        opcode_next = opcode_reg;
        halted_next = halted_reg;
        done_next   = 1'b0;
        case (ring_reg)
            T1: if (adv) ring_next = T2;
            T2: if (adv) ring_next = T3;
            T3: if (adv) begin
                ring_next   = T4;
                opcode_next = instr_opcode;
            end
            T4: if (adv) begin
                if (dec_reg.hlt) begin
                    halted_next = 1'b1;
                end else if (short_end) begin
                    ring_next = T1;
                    done_next = 1'b1;
                end else begin
                    ring_next = T5;
                end
            end
            T5: if (adv) ring_next = T6;
            T6: if (adv) begin
                ring_next = T1;
                done_next = 1'b1;
            end
            default: ring_next = T1;
        endcase
    end

    // Decode the value the latch is about to hold so the lines line up with the ring.
    sap_1_opcode_decoder u_decoder (
        .opcode (opcode_next),
        .lda    (dec_lda),
        .add    (dec_add),
        .sub    (dec_sub),
        .out    (dec_out),
        .hlt    (dec_hlt)
    );

    assign dec_raw    = '{lda: dec_lda, add: dec_add, sub: dec_sub, out: dec_out, hlt: dec_hlt};
    assign dec_window = (ring_next == T4) || (ring_next == T5) || (ring_next == T6);
    assign dec_next   = dec_window ? dec_raw : '0;

    always_ff @(posedge CLK) begin
        if (!CLRbar) begin
            ring_reg      <= T1;
            opcode_reg    <= 4'b0000;
            step_prev_reg <= 1'b1;
            halted_reg    <= 1'b0;
            done_reg      <= 1'b0;
            dec_reg       <= '0;
        end else begin
            ring_reg      <= ring_next;
            opcode_reg    <= opcode_next;
            step_prev_reg <= step;
            halted_reg    <= halted_next;
            done_reg      <= done_next;
            dec_reg       <= dec_next;
        end
    end

    assign ring_counter = ring_reg;
    assign LDA          = dec_reg.lda;
    assign ADD          = dec_reg.add;
    assign SUB          = dec_reg.sub;
    assign OUT          = dec_reg.out;
    assign HLT          = dec_reg.hlt;
    assign halted       = halted_reg;
    assign instr_done   = done_reg;

endmodule

// File: tb/tb_sap_1_controller_sequencer.sv
// Scoreboard bench for the SAP-1 controller-sequencer; runs a 6-state and a short-cycle instance side by side.
module tb_sap_1_controller_sequencer;
    import sap_1_controller_sequencer_pkg::*;

    localparam logic [4:0] D_NONE = 5'b00000;
    localparam logic [4:0] D_LDA  = 5'b10000;
    localparam logic [4:0] D_ADD  = 5'b01000;
    localparam logic [4:0] D_SUB  = 5'b00100;
    localparam logic [4:0] D_OUT  = 5'b00010;
    localparam logic [4:0] D_HLT  = 5'b00001;

    logic       CLK = 1'b0;
    logic       CLRbar;
    logic [3:0] instr_opcode;
    logic       run_mode;
    logic       step;

    logic [5:0] ring_counter, sc_ring_counter;
    logic       LDA, ADD, SUB, OUT, HLT, halted, instr_done;
    logic       sc_lda, sc_add, sc_sub, sc_out, sc_hlt, sc_halted, sc_instr_done;

    int checks = 0;
    int errors = 0;

    logic [11:0] q_exp[$];
    logic [11:0] q_sc[$];

    always #5 CLK = ~CLK;

    sap_1_controller_sequencer #(.SHORT_CYCLE(1'b0)) dut (
        .CLK(CLK), .CLRbar(CLRbar), .instr_opcode(instr_opcode), .run_mode(run_mode), .step(step),
        .ring_counter(ring_counter), .LDA(LDA), .ADD(ADD), .SUB(SUB), .OUT(OUT), .HLT(HLT),
        .halted(halted), .instr_done(instr_done)
    );

    sap_1_controller_sequencer #(.SHORT_CYCLE(1'b1)) dut_sc (
        .CLK(CLK), .CLRbar(CLRbar), .instr_opcode(instr_opcode), .run_mode(run_mode), .step(step),
        .ring_counter(sc_ring_counter), .LDA(sc_lda), .ADD(sc_add), .SUB(sc_sub), .OUT(sc_out), .HLT(sc_hlt),
        .halted(sc_halted), .instr_done(sc_instr_done)
    );

    function automatic logic [11:0] mk(input logic [5:0] ring, input logic [4:0] dec,
                                       input logic h, input logic d);
        return {ring, dec, h, d};
    endfunction

    function automatic logic [4:0] dec_of(input logic [3:0] opc);
        case (opc)
            4'h0:    return D_LDA;
            4'h1:    return D_ADD;
            4'h2:    return D_SUB;
            4'hE:    return D_OUT;
            4'hF:    return D_HLT;
            default: return D_NONE;
        endcase
    endfunction

    function automatic logic [5:0] ring_at(input int idx);
        logic [5:0] one;
        one = 6'b000001;
        return one << idx;
    endfunction

    function automatic logic [11:0] obs_main();
        return {ring_counter, LDA, ADD, SUB, OUT, HLT, halted, instr_done};
    endfunction

    function automatic logic [11:0] obs_sc();
        return {sc_ring_counter, sc_lda, sc_add, sc_sub, sc_out, sc_hlt, sc_halted, sc_instr_done};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] opc, input logic rm, input logic st);
        instr_opcode = opc;
        run_mode     = rm;
        step         = st;
        CLRbar       = 1'b0;
        tick();
        CLRbar       = 1'b1;
    endtask

    task automatic test_reset();
        logic [11:0] e;
        run_mode = 1'b1; step = 1'b1; instr_opcode = 4'h7; CLRbar = 1'b0;
        for (int i = 0; i < 2; i++) begin
            q_exp.push_back(mk(T1, D_NONE, 1'b0, 1'b0));
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs_main(), e);
            end
            checks++;
            if (obs_sc() !== e) begin
                errors++;
                $display("FAIL reset_sc cyc%0d: got %b want %b", i, obs_sc(), e);
            end
        end
    endtask

    task automatic test_lda_free_run();
        logic [11:0] tbl [7];
        logic [11:0] e;
        tbl = '{mk(T2, D_NONE, 1'b0, 1'b0), mk(T3, D_NONE, 1'b0, 1'b0), mk(T4, D_LDA, 1'b0, 1'b0),
                mk(T5, D_LDA, 1'b0, 1'b0), mk(T6, D_LDA, 1'b0, 1'b0), mk(T1, D_NONE, 1'b0, 1'b1),
                mk(T2, D_NONE, 1'b0, 1'b0)};
        apply_reset(4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            q_exp.push_back(tbl[i]);
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL lda_free_run cyc%0d: got %b want %b", i, obs_main(), e);
            end
        end
    endtask

    task automatic test_halt();
        logic [11:0] e;
        apply_reset(4'hF, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i >= 25) begin
                run_mode = 1'b0;
                step     = ~step;
            end
            if (i == 0)      e = mk(T2, D_NONE, 1'b0, 1'b0);
            else if (i == 1) e = mk(T3, D_NONE, 1'b0, 1'b0);
            else if (i == 2) e = mk(T4, D_HLT, 1'b0, 1'b0);
            else             e = mk(T4, D_HLT, 1'b1, 1'b0);
            q_exp.push_back(e);
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL halt cyc%0d: got %b want %b", i, obs_main(), e);
            end
        end
        CLRbar = 1'b0;
        step   = 1'b0;
        q_exp.push_back(mk(T1, D_NONE, 1'b0, 1'b0));
        tick();
        e = q_exp.pop_front();
        checks++;
        if (obs_main() !== e) begin
            errors++;
            $display("FAIL halt_clear: got %b want %b", obs_main(), e);
        end
        CLRbar = 1'b1;
    endtask

    task automatic test_single_step();
        logic [11:0] e;
        logic        st [16];
        logic [5:0]  rg [16];
        st = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b1, 1'b0, 1'b1};
        rg = '{T1, T1, T2, T2, T2, T2, T2, T2, T2, T2, T2, T2, T2, T3, T3, T4};
        apply_reset(4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step = st[i];
            q_exp.push_back(mk(rg[i], (rg[i] == T4) ? D_LDA : D_NONE, 1'b0, 1'b0));
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL single_step cyc%0d: got %b want %b", i, obs_main(), e);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_short_cycle();
        logic [11:0] e;
        logic [5:0]  r;
        apply_reset(4'hE, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            r = ring_at(i % 6);
            q_exp.push_back(mk(r, (i % 6 >= 3) ? D_OUT : D_NONE, 1'b0, (i % 6) == 0));
            r = ring_at(i % 4);
            q_sc.push_back(mk(r, (i % 4 == 3) ? D_OUT : D_NONE, 1'b0, (i % 4) == 0));
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL out_full cyc%0d: got %b want %b", i, obs_main(), e);
            end
            e = q_sc.pop_front();
            checks++;
            if (obs_sc() !== e) begin
                errors++;
                $display("FAIL out_short cyc%0d: got %b want %b", i, obs_sc(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] e;
        logic [11:0] tbl [11];
        tbl = '{mk(T2, D_NONE, 1'b0, 1'b0), mk(T3, D_NONE, 1'b0, 1'b0), mk(T4, D_ADD, 1'b0, 1'b0),
                mk(T5, D_ADD, 1'b0, 1'b0), mk(T1, D_NONE, 1'b0, 1'b0),
                mk(T2, D_NONE, 1'b0, 1'b0), mk(T3, D_NONE, 1'b0, 1'b0), mk(T4, D_SUB, 1'b0, 1'b0),
                mk(T5, D_SUB, 1'b0, 1'b0), mk(T6, D_SUB, 1'b0, 1'b0), mk(T1, D_NONE, 1'b0, 1'b1)};
        apply_reset(4'h1, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            CLRbar = (i == 4) ? 1'b0 : 1'b1;
            if (i == 4) instr_opcode = 4'h2;
            q_exp.push_back(tbl[i]);
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs_main(), e);
            end
        end
        CLRbar = 1'b1;
    endtask

    task automatic test_illegal();
        logic [11:0] e;
        apply_reset(4'h5, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            q_exp.push_back(mk(ring_at(i % 6), D_NONE, 1'b0, (i % 6) == 0));
            q_sc.push_back(mk(ring_at(i % 4), D_NONE, 1'b0, (i % 4) == 0));
            tick();
            e = q_exp.pop_front();
            checks++;
            if (obs_main() !== e) begin
                errors++;
                $display("FAIL illegal cyc%0d: got %b want %b", i, obs_main(), e);
            end
            e = q_sc.pop_front();
            checks++;
            if (obs_sc() !== e) begin
                errors++;
                $display("FAIL illegal_sc cyc%0d: got %b want %b", i, obs_sc(), e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        logic [3:0]  opcs [5];
        int          nxt;
        opcs = '{4'h1, 4'h2, 4'hE, 4'h0, 4'h5};
        apply_reset(opcs[0], 1'b1, 1'b0);
        for (int j = 0; j < 5; j++) begin
            for (int p = 0; p < 6; p++) begin
                // After the T3 edge the IR input is scrambled; the latched opcode must hold.
                instr_opcode = (p <= 2) ? opcs[j] : ~opcs[j];
                nxt = (p + 1) % 6;
                q_exp.push_back(mk(ring_at(nxt), (nxt >= 3) ? dec_of(opcs[j]) : D_NONE, 1'b0, nxt == 0));
                tick();
                e = q_exp.pop_front();
                checks++;
                if (obs_main() !== e) begin
                    errors++;
                    $display("FAIL back_to_back instr%0d ph%0d: got %b want %b", j, p, obs_main(), e);
                end
            end
        end
    endtask

    initial begin
        CLRbar       = 1'b0;
        run_mode     = 1'b0;
        step         = 1'b0;
        instr_opcode = 4'h0;
        test_reset();
        test_lda_free_run();
        test_halt();
        test_single_step();
        test_short_cycle();
        test_reset_mid();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
